// File: rtl/multi_row_delay_buffer.sv
// Multi-channel row delay line: holds side-band pixel data for a runtime number
// of rows so it leaves aligned with a neighbouring kernel stage.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif

module multi_row_delay_buffer #(
    parameter int NUM_CHANNELS   = 3,
    parameter int CHANNEL_WIDTH  = 8,
    parameter int MAX_COLS       = 1288,
    parameter int MAX_DELAY_ROWS = 4,
    parameter int PIXEL_LATENCY  = 2,
    localparam int DEPTH = MAX_DELAY_ROWS * MAX_COLS,
    localparam int AW    = $clog2(DEPTH + 1),
    localparam int DW    = $clog2(MAX_DELAY_ROWS + 1)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enable,
    input  logic [DW-1:0]                           delay_rows,
    input  logic                                    dvi,
    input  logic [`DTYPE_WIDTH-1:0]                 dtypei,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   datai,
    output logic                                    dvo,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   datao,
    output logic [AW-1:0]                           fill_level,
    output logic                                    overflow,
    output logic                                    underflow
);

    localparam int                DATA_W    = NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]     DEPTH_C   = AW'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DW-1:0]     MAX_DLY   = DW'(MAX_DELAY_ROWS);

    logic [DATA_W-1:0] mem [DEPTH];

    logic                     pix;
    logic                     fs;
    logic                     row_end;
    logic                     flush;
    logic                     pop_req;
    logic                     pop;
    logic                     wr_en;
    logic                     rd_en;
    logic [DW-1:0]            lat_req;
    logic [PIXEL_LATENCY-1:0] pipe_shift;

    logic [ADDR_W-1:0]        waddr_q, waddr_d;
    logic [ADDR_W-1:0]        raddr_q, raddr_d;
    logic [AW-1:0]            fill_q, fill_d;
    logic [DW-1:0]            row_cnt_q, row_cnt_d;
    logic                     valid_row_q, valid_row_d;
    logic [DW-1:0]            delay_lat_q, delay_lat_d;
    logic [PIXEL_LATENCY-1:0] pop_pipe_q, pop_pipe_d;
    logic                     ovf_q, ovf_d;
    logic                     udf_q, udf_d;
    logic                     dvo_q, dvo_d;
    logic [DATA_W-1:0]        datao_q, datao_d;

    assign pix     = dvi && (|(dtypei & `DTYPE_PIXEL_MASK));
    assign fs      = dvi && (dtypei == `DTYPE_FRAME_START);
    assign row_end = dvi && (dtypei == `DTYPE_ROW_END);
    assign flush   = !enable || fs;
    assign lat_req = (delay_rows > MAX_DLY) ? MAX_DLY : delay_rows;

    // Pop requests only for pixels of rows past the delay; they surface
    // PIXEL_LATENCY cycles later at the pipe tail.
    assign pop_req = pix && valid_row_q;
    assign pop     = pop_pipe_q[PIXEL_LATENCY-1];

    generate
        if (PIXEL_LATENCY == 1) begin : g_pipe_single
            assign pipe_shift = pop_req;
        end else begin : g_pipe_multi
            assign pipe_shift = {pop_pipe_q[PIXEL_LATENCY-2:0], pop_req};
        end
    endgenerate

    // Occupancy is judged before this cycle's write, so a full buffer still pops.
    assign wr_en = pix && !flush && (fill_q < DEPTH_C);
    assign rd_en = pop && !flush && (fill_q != '0);

    always_comb begin
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        fill_d      = fill_q;
        row_cnt_d   = row_cnt_q;
        valid_row_d = valid_row_q;
        delay_lat_d = delay_lat_q;
        pop_pipe_d  = pop_pipe_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        dvo_d       = 1'b0;
        datao_d     = datao_q;

        if (flush) begin
            waddr_d     = '0;
            raddr_d     = '0;
            fill_d      = '0;
            row_cnt_d   = '0;
            pop_pipe_d  = '0;
            ovf_d       = 1'b0;
            udf_d       = 1'b0;
            delay_lat_d = lat_req;
            valid_row_d = (lat_req == '0);
        end else begin
            pop_pipe_d = pipe_shift;

            if (wr_en) begin
                waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
            end else if (pix) begin
                ovf_d = 1'b1;
            end

            if (rd_en) begin
                raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
                datao_d = mem[raddr_q];
                dvo_d   = 1'b1;
            end else if (pop) begin
                udf_d = 1'b1;
            end

            case ({wr_en, rd_en})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase

            if (row_end && !valid_row_q) begin
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q + 1'b1 == delay_lat_q) begin
                    valid_row_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr_q     <= '0;
            raddr_q     <= '0;
            fill_q      <= '0;
            row_cnt_q   <= '0;
            valid_row_q <= 1'b0;
            delay_lat_q <= '0;
            pop_pipe_q  <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            dvo_q       <= 1'b0;
            datao_q     <= '0;
        end else begin
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            fill_q      <= fill_d;
            row_cnt_q   <= row_cnt_d;
            valid_row_q <= valid_row_d;
            delay_lat_q <= delay_lat_d;
            pop_pipe_q  <= pop_pipe_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            dvo_q       <= dvo_d;
            datao_q     <= datao_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr_q] <= datai;
        end
    end

    assign dvo        = dvo_q;
    assign datao      = datao_q;
    assign fill_level = fill_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_multi_row_delay_buffer.sv
// Randomised bench for multi_row_delay_buffer: a queue-based reference model
// feeds a scoreboard that a separate monitor drains on every dvo pulse.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif

module tb_multi_row_delay_buffer;

    localparam int NCH   = 3;
    localparam int CW    = 8;
    localparam int MC    = 16;
    localparam int MDR   = 4;
    localparam int PL    = 2;
    localparam int DEPTH = MDR * MC;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int DW    = $clog2(MDR + 1);
    localparam int DWID  = NCH * CW;

    localparam logic [`DTYPE_WIDTH-1:0] DT_FS   = `DTYPE_FRAME_START;
    localparam logic [`DTYPE_WIDTH-1:0] DT_RE   = `DTYPE_ROW_END;
    localparam logic [`DTYPE_WIDTH-1:0] DT_MASK = `DTYPE_PIXEL_MASK;
    localparam logic [`DTYPE_WIDTH-1:0] DT_PIX  = 8'h10;
    localparam logic [`DTYPE_WIDTH-1:0] DT_PIX2 = 8'h40;
    localparam logic [`DTYPE_WIDTH-1:0] DT_RS   = 8'h04;
    localparam logic [`DTYPE_WIDTH-1:0] DT_FE   = 8'h02;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic [DW-1:0]           delay_rows;
    logic                    dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei;
    logic [DWID-1:0]         datai;
    logic                    dvo;
    logic [DWID-1:0]         datao;
    logic [AW-1:0]           fill_level;
    logic                    overflow;
    logic                    underflow;

    multi_row_delay_buffer #(
        .NUM_CHANNELS   (NCH),
        .CHANNEL_WIDTH  (CW),
        .MAX_COLS       (MC),
        .MAX_DELAY_ROWS (MDR),
        .PIXEL_LATENCY  (PL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .delay_rows (delay_rows),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .datai      (datai),
        .dvo        (dvo),
        .datao      (datao),
        .fill_level (fill_level),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DWID-1:0] data;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    logic [DWID-1:0] m_fifo[$];
    int              m_pops[$];
    int              m_lat;
    int              m_rows;
    bit              m_valid;
    bit              m_ovf;
    bit              m_udf;
    exp_t            mon_e;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_fifo.delete();
        m_pops.delete();
        m_lat   = 0;
        m_rows  = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Behaviour of one cycle, in terms of a FIFO of stored pixels and a list
    // of cycles at which a pop is due.
    task automatic model_step();
        bit   pix;
        bit   fs;
        bit   re;
        bit   do_pop;
        int   size0;
        exp_t e;
        pix = dvi && (|(dtypei & DT_MASK));
        fs  = dvi && (dtypei == DT_FS);
        re  = dvi && (dtypei == DT_RE);
        if (!enable || fs) begin
            m_fifo.delete();
            m_pops.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_rows  = 0;
            m_lat   = (int'(delay_rows) > MDR) ? MDR : int'(delay_rows);
            m_valid = (m_lat == 0);
        end else begin
            size0  = m_fifo.size();
            do_pop = (m_pops.size() > 0) && (m_pops[0] == cyc);
            if (do_pop) begin
                void'(m_pops.pop_front());
                if (size0 > 0) begin
                    e.data = m_fifo.pop_front();
                    e.cyc  = cyc + 1;
                    sb.push_back(e);
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (pix) begin
                if (size0 < DEPTH) m_fifo.push_back(datai);
                else               m_ovf = 1'b1;
            end
            if (pix && m_valid) m_pops.push_back(cyc + PL);
            if (re && !m_valid) begin
                m_rows++;
                if (m_rows == m_lat) m_valid = 1'b1;
            end
        end
    endtask

    task automatic step(input bit en, input logic [`DTYPE_WIDTH-1:0] dt, input bit v,
                        input logic [DWID-1:0] d);
        enable = en;
        dtypei = dt;
        dvi    = v;
        datai  = d;
        model_step();
        @(posedge clk);
        #1;
        chk("fill_level", int'(fill_level), m_fifo.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dvi   = 1'b0;
        model_clear();
        #2;
        chk("reset_dvo", int'(dvo), 0);
        chk("reset_datao", int'(datao), 0);
        chk("reset_fill", int'(fill_level), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_underflow", int'(underflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'h00, 1'b0, '0);
    endtask

    // abort: 0 none, 1 enable dropped mid last row, 2 reset mid last row
    task automatic frame(input int dly, input int nrows, input int minlen, input int maxlen,
                         input bit gaps, input int mid_dly, input int abort);
        int len;
        delay_rows = DW'(dly);
        step(1'b1, DT_FS, 1'b1, '0);
        for (int r = 0; r < nrows; r++) begin
            len = $urandom_range(maxlen, minlen);
            if (mid_dly >= 0 && r == 1) delay_rows = DW'(mid_dly);
            for (int c = 0; c < len; c++) begin
                if (gaps && $urandom_range(3, 0) == 0) begin
                    if ($urandom_range(1, 0) == 1) step(1'b1, DT_RS, 1'b1, DWID'($urandom));
                    else                           step(1'b1, DT_PIX, 1'b0, DWID'($urandom));
                end
                if (abort != 0 && r == nrows - 1 && c == len / 2) begin
                    if (abort == 1) begin
                        for (int k = 0; k < 3; k++) step(1'b0, DT_PIX, 1'b1, DWID'($urandom));
                    end else begin
                        do_reset();
                    end
                    idle(2);
                    return;
                end
                step(1'b1, ($urandom_range(1, 0) == 1) ? DT_PIX : DT_PIX2, 1'b1, DWID'($urandom));
            end
            step(1'b1, DT_RE, 1'b1, '0);
        end
        step(1'b1, DT_FE, 1'b1, '0);
        idle(PL + 2);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL dvo_missing: no pulse at cycle %0d, expected datao %0h", sb[0].cyc, sb[0].data);
                void'(sb.pop_front());
            end
            if (dvo) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL dvo_unexpected: pulse at cycle %0d with datao %0h, none expected", cyc, datao);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc != cyc || mon_e.data !== datao) begin
                        n_fail++;
                        $display("FAIL dvo_data: got %0h at cycle %0d expected %0h at cycle %0d",
                                 datao, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        enable     = 1'b0;
        delay_rows = '0;
        dvi        = 1'b0;
        dtypei     = '0;
        datai      = '0;
        do_reset();

        frame(2, 4, 8, 8, 1'b0, -1, 0);
        frame(0, 3, 8, 8, 1'b0, -1, 0);
        frame(0, 3, 5, 10, 1'b1, -1, 0);
        frame(4, 6, 20, 20, 1'b0, -1, 0);
        frame(1, 3, 20, 20, 1'b0, -1, 0);
        frame(1, 4, 6, 10, 1'b0, 3, 0);
        frame(3, 5, 6, 10, 1'b0, -1, 0);
        frame(1, 2, 7, 7, 1'b0, -1, 1);
        frame(2, 3, 8, 8, 1'b0, -1, 0);
        frame(1, 2, 7, 7, 1'b0, -1, 2);
        frame(7, 6, 4, 8, 1'b1, -1, 0);

        for (int f = 0; f < 30; f++) begin
            frame($urandom_range(7, 0), $urandom_range(6, 1), 1, 20, 1'b1,
                  ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1,
                  ($urandom_range(9, 0) == 0) ? int'($urandom_range(2, 1)) : 0);
        end

        idle(PL + 4);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
